// File: rtl/task_packet_driver_if.sv
// rtl/task_packet_driver_if.sv - task_in/task_out handshake bundle between manager and task
interface task_packet_driver_if;
  logic        task_data_request;
  logic        task_data_valid;
  logic [7:0]  task_data;
  logic        task_data_last;
  logic        task_manager_ready;
  logic        task_answer_ready;
  logic [31:0] task_answer_data;
  logic        task_answer_data_last;
  logic [11:0] task_answer_packet_size_in_bytes;

  modport master (
    input  task_data_request,
    output task_data_valid,
    output task_data,
    output task_data_last,
    output task_manager_ready,
    input  task_answer_ready,
    input  task_answer_data,
    input  task_answer_data_last,
    input  task_answer_packet_size_in_bytes
  );

  modport slave (
    output task_data_request,
    input  task_data_valid,
    input  task_data,
    input  task_data_last,
    input  task_manager_ready,
    output task_answer_ready,
    output task_answer_data,
    output task_answer_data_last,
    output task_answer_packet_size_in_bytes
  );
endinterface

// File: rtl/task_packet_driver.sv
// rtl/task_packet_driver.sv - manager-side packet sender and answer collector for a task_N block
module task_packet_driver #(
  parameter int MAX_BYTES      = 256,
  parameter int MAX_WORDS      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_wr_en,
  input  logic [$clog2(MAX_BYTES)-1:0] i_wr_addr,
  input  logic [7:0]                   i_wr_data,
  input  logic [11:0]                  i_len,
  input  logic                         i_start,
  task_packet_driver_if.master         task_if,
  input  logic [$clog2(MAX_WORDS)-1:0] i_rd_addr,
  output logic [31:0]                  o_rd_data,
  output logic [3:0]                   o_words,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [2:0]                   o_err
);

  localparam int AW  = $clog2(MAX_BYTES);
  localparam int WAW = $clog2(MAX_WORDS);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [11:0]   LEN_MAX   = 12'(MAX_BYTES);
  localparam logic [3:0]    WORDS_MAX = 4'(MAX_WORDS);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT_CYCLES);

  logic [1:0]    state_q, state_d;
  logic [11:0]   len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    words_q, words_d;
  logic [2:0]    err_q, err_d;
  logic [11:0]   acc_q, acc_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          ans_last_q, ans_last_d;
  logic [31:0]   rd_q;

  logic [7:0]  pkt_mem [MAX_BYTES];
  logic [31:0] ans_mem [MAX_WORDS];

  logic        in_send, in_collect, is_last, byte_xfer, word_xfer, word_store, size_bad;
  logic [11:0] acc_inc;

  assign in_send    = (state_q == S_SEND);
  assign in_collect = (state_q == S_COLLECT);
  assign is_last    = in_send && (12'(idx_q) == (len_q - 12'd1));
  assign byte_xfer  = in_send && task_if.task_data_request;
  assign word_xfer  = (in_send || in_collect) && task_if.task_answer_ready;
  assign word_store = word_xfer && (words_q != WORDS_MAX);
  // Accepted-word count includes dropped words so the size check sees what the task sent.
  assign acc_inc    = (acc_q == 12'hFFF) ? acc_q : acc_q + 12'd1;
  assign size_bad   = ({2'b00, task_if.task_answer_packet_size_in_bytes} != {acc_inc, 2'b00});

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    words_d    = words_q;
    err_d      = err_q;
    acc_d      = acc_q;
    idle_d     = idle_q;
    ans_last_d = ans_last_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if ((i_len != 12'd0) && (i_len <= LEN_MAX)) begin
            len_d      = i_len;
            idx_d      = '0;
            err_d      = 3'b000;
            words_d    = 4'd0;
            acc_d      = 12'd0;
            ans_last_d = 1'b0;
            state_d    = S_SEND;
          end else begin
            err_d   = 3'b100;
            state_d = S_DONE;
          end
        end
      end
      S_SEND: begin
        idle_d = '0;
        if (byte_xfer) begin
          idx_d = idx_q + AW'(1);
          if (is_last) state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (ans_last_q) begin
          state_d = S_DONE;
        end else if (word_xfer) begin
          idle_d = '0;
        end else if ((idle_q + TW'(1)) == TO_LIMIT) begin
          err_d[0] = 1'b1;
          state_d  = S_DONE;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Answer capture runs in both SEND and COLLECT so early answers are not lost.
    if (word_xfer) begin
      acc_d = acc_inc;
      if (word_store) words_d  = words_q + 4'd1;
      else            err_d[1] = 1'b1;
      if (task_if.task_answer_data_last) begin
        ans_last_d = 1'b1;
        if (size_bad)   err_d[2] = 1'b1;
        if (in_collect) state_d  = S_DONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      len_q      <= 12'd0;
      idx_q      <= '0;
      words_q    <= 4'd0;
      err_q      <= 3'b000;
      acc_q      <= 12'd0;
      idle_q     <= '0;
      ans_last_q <= 1'b0;
      rd_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      words_q    <= words_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      idle_q     <= idle_d;
      ans_last_q <= ans_last_d;
      rd_q       <= ans_mem[i_rd_addr];
    end
  end

  // Buffer contents survive reset; only writes are gated.
  always_ff @(posedge i_clk) begin
    if (i_rstn && i_wr_en && (state_q == S_IDLE)) pkt_mem[i_wr_addr] <= i_wr_data;
    if (i_rstn && word_store) ans_mem[words_q[WAW-1:0]] <= task_if.task_answer_data;
  end

  assign task_if.task_data_valid    = in_send;
  assign task_if.task_data          = in_send ? pkt_mem[idx_q] : 8'h00;
  assign task_if.task_data_last     = is_last;
  assign task_if.task_manager_ready = in_send || in_collect;

  assign o_busy    = in_send || in_collect;
  assign o_done    = (state_q == S_DONE);
  assign o_err     = err_q;
  assign o_words   = words_q;
  assign o_rd_data = rd_q;

endmodule

// File: tb/tb_task_packet_driver.sv
// tb/tb_task_packet_driver.sv - scoreboard bench for task_packet_driver
module tb_task_packet_driver;
  localparam int MAXB = 256;
  localparam int MAXW = 8;
  localparam int TO   = 4096;

  logic        clk = 1'b0;
  logic        rstn, wr_en, start;
  logic [7:0]  wr_addr, wr_data;
  logic [11:0] len;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  words;
  logic        busy, done;
  logic [2:0]  err;

  always #5 clk = ~clk;

  task_packet_driver_if tif();

  task_packet_driver #(.MAX_BYTES(MAXB), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_len(len), .i_start(start), .task_if(tif), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_words(words), .o_busy(busy), .o_done(done), .o_err(err)
  );

  typedef struct packed {logic [7:0] data; logic last;} byte_t;
  typedef struct packed {logic [2:0] err; logic [3:0] words; logic chk_to;} done_t;

  byte_t       exp_bytes[$];
  done_t       exp_done[$];
  logic [31:0] exp_rd[$];

  int   n_chk = 0, n_fail = 0, cyc = 0, req_mode = 0;
  bit   rd_strobe = 0;
  logic [7:0] pkt [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a byte, a done pulse or read data.
  bit         hold = 0, rd_pend = 0;
  logic [7:0] held;
  int         last_cyc = 0;
  byte_t      mb;
  done_t      md;
  initial begin
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_data", rd_data, exp_rd.pop_front());
      end
      rd_pend = rd_strobe;
      if (tif.task_data_valid) begin
        if (hold) check("data_stable", tif.task_data, held);
        if (tif.task_data_request) begin
          if (exp_bytes.size() == 0) check("byte_unexpected", 1, 0);
          else begin
            mb = exp_bytes.pop_front();
            check("byte_data", tif.task_data, mb.data);
            check("byte_last", tif.task_data_last, mb.last);
          end
          if (tif.task_data_last) last_cyc = cyc;
        end
        hold = !tif.task_data_request;
        held = tif.task_data;
      end else begin
        hold = 0;
      end
      if (done) begin
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          md = exp_done.pop_front();
          check("done_err", err, md.err);
          check("done_words", words, md.words);
          if (md.chk_to) check("timeout_cycles", cyc - last_cyc, TO + 1);
        end
      end
    end
  end

  // Request driver: 0 = held high, 1 = alternating, other = low.
  initial begin
    tif.task_data_request = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (req_mode)
        0:       tif.task_data_request = 1'b1;
        1:       tif.task_data_request = ~tif.task_data_request;
        default: tif.task_data_request = 1'b0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pkt();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = pkt[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic push_pkt();
    for (int i = 0; i < 4; i++) exp_bytes.push_back(byte_t'{pkt[i], (i == 3)});
  endtask

  task automatic start_pkt(input logic [11:0] l);
    len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_collect(output int k);
    k = 0;
    while (!(busy && !tif.task_data_valid) && k < 200) begin
      tick();
      k++;
    end
    check("reach_collect", busy && !tif.task_data_valid, 1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic [11:0] sz);
    int k;
    tif.task_answer_ready = 1'b1; tif.task_answer_data = d;
    tif.task_answer_data_last = l; tif.task_answer_packet_size_in_bytes = sz;
    k = 0;
    while (!tif.task_manager_ready && k < 50) begin
      tick();
      k++;
    end
    if (!tif.task_manager_ready) check("manager_ready_wait", 0, 1);
    tick();
    tif.task_answer_ready = 1'b0; tif.task_answer_data_last = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", done, 1);
    tick();
  endtask

  task automatic read_chk(input logic [2:0] a, input logic [31:0] e);
    rd_addr = a; rd_strobe = 1'b1;
    exp_rd.push_back(e);
    tick();
    rd_strobe = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  int k;
  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0; start = 1'b0; rd_addr = '0;
    tif.task_answer_ready = 1'b0; tif.task_answer_data = '0;
    tif.task_answer_data_last = 1'b0; tif.task_answer_packet_size_in_bytes = '0;
    req_mode = 0;
    repeat (3) tick();
    check("rst_valid", tif.task_data_valid, 0);
    check("rst_last", tif.task_data_last, 0);
    check("rst_data", tif.task_data, 0);
    check("rst_mgr_ready", tif.task_manager_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_words", words, 0);
    check("rst_rd_data", rd_data, 0);
    rstn = 1'b1;
    tick();

    // Basic packet, request held high, one answer word.
    load_pkt();
    push_pkt();
    start_pkt(12'd4);
    check("first_byte_latency", tif.task_data_valid, 1);
    wait_collect(k);
    check("send_cycles", k, 4);
    exp_done.push_back(done_t'{3'b000, 4'd1, 1'b0});
    send_word(32'h1A5, 1'b1, 12'd4);
    wait_done(20);
    read_chk(3'd0, 32'h1A5);

    // Alternating request; size mismatch on the answer.
    req_mode = 1;
    push_pkt();
    start_pkt(12'd4);
    wait_collect(k);
    req_mode = 0;
    exp_done.push_back(done_t'{3'b100, 4'd1, 1'b0});
    send_word(32'hBEEF, 1'b1, 12'd8);
    wait_done(20);
    read_chk(3'd0, 32'hBEEF);

    // Ten answer words into an eight-word buffer.
    push_pkt();
    start_pkt(12'd4);
    wait_collect(k);
    exp_done.push_back(done_t'{3'b010, 4'd8, 1'b0});
    for (int i = 0; i < 10; i++) send_word(32'hA000 + 32'(i), (i == 9), 12'd40);
    wait_done(20);
    read_chk(3'd0, 32'hA000);
    read_chk(3'd7, 32'hA007);

    // No answer: timeout.
    push_pkt();
    start_pkt(12'd4);
    wait_collect(k);
    exp_done.push_back(done_t'{3'b001, 4'd0, 1'b1});
    wait_done(TO + 20);

    // Bad lengths.
    exp_done.push_back(done_t'{3'b100, 4'd0, 1'b0});
    start_pkt(12'd0);
    check("len0_done_next", done, 1);
    check("len0_no_valid", tif.task_data_valid, 0);
    wait_done(5);
    exp_done.push_back(done_t'{3'b100, 4'd0, 1'b0});
    start_pkt(12'(MAXB + 1));
    check("lenmax_done_next", done, 1);
    check("lenmax_busy", busy, 0);
    wait_done(5);

    // Reset mid-packet, then resend from byte 0.
    push_pkt();
    start_pkt(12'd4);
    tick();
    tick();
    rstn = 1'b0; req_mode = 2;
    tick();
    check("reset_valid_drop", tif.task_data_valid, 0);
    check("reset_last_drop", tif.task_data_last, 0);
    check("reset_busy_drop", busy, 0);
    check("bytes_before_reset", exp_bytes.size(), 2);
    exp_bytes.delete();
    rstn = 1'b1; req_mode = 0;
    tick();
    push_pkt();
    start_pkt(12'd4);
    wait_collect(k);
    exp_done.push_back(done_t'{3'b000, 4'd1, 1'b0});
    send_word(32'h77, 1'b1, 12'd4);
    wait_done(20);
    read_chk(3'd0, 32'h77);

    repeat (3) tick();
    check("bytes_drained", exp_bytes.size(), 0);
    check("done_drained", exp_done.size(), 0);
    check("rd_drained", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
